// File: rtl/fifo_read_ctrl.sv
// Read-side controller for fifo_sync: drains the FIFO into a two-entry ring and presents it as valid/ready.
// Optional delivered-word counter enabled by defining FIFO_READ_CTRL_CNT_EN; otherwise word_count is tied to 0.
module fifo_read_ctrl #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_read,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] word_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t          occ;
  occ_t          occ_next;
  logic          inflight;
  logic [DW-1:0] slot [2];
  logic          head;
  logic          tail;
  logic          pop;
  logic          capture;
  logic [1:0]    fill;

  function automatic logic [1:0] occ_level(input occ_t s);
    logic [1:0] lvl;
    lvl = 2'd0;
    case (s)
      OCC_ONE: lvl = 2'd1;
      OCC_TWO: lvl = 2'd2;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

  assign pop       = out_valid & out_ready;
  assign capture   = inflight;
  // Count the in-flight word as already occupying a slot so the ring can never overflow.
  assign fill      = occ_level(occ) + {1'b0, inflight};
  assign fifo_read = enable & ~fifo_empty & ((fill < 2'd2) | pop);
  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = slot[head];

  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: begin
        if (capture) occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (capture && !pop)      occ_next = OCC_TWO;
        else if (!capture && pop) occ_next = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (!capture && pop) occ_next = OCC_ONE;
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      occ      <= occ_next;
      inflight <= fifo_read;
      if (capture) tail <= ~tail;
      if (pop)     head <= ~head;
    end
  end

  // Slots are cleared too, so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (capture) begin
      slot[tail] <= fifo_data;
    end
  end

`ifdef FIFO_READ_CTRL_CNT_EN
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (pop) begin
      count <= count + 1'b1;
    end
  end

  assign word_count = count;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a behavioural FIFO feeds the DUT and a scoreboard queue checks delivery order.
module tb_fifo_read_ctrl;
  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_read;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] word_count;

  fifo_read_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: word appears on fifo_data after the edge that samples read.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_data = '0;
  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  int            cyc_no;
  int            n_reads;
  int            n_pop;
  int            first_read;
  int            first_pop;
  int            last_pop;
  int            cnt_model = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] wc_expected();
`ifdef FIFO_READ_CTRL_CNT_EN
    return 32'(cnt_model % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic clr_stats();
    cyc_no     = 0;
    n_reads    = 0;
    n_pop      = 0;
    first_read = -1;
    first_pop  = -1;
    last_pop   = -1;
  endtask

  task automatic observe();
    cyc_no++;
    check("word_count", 32'(word_count), wc_expected());
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_data));
    end
    if (fifo_read) begin
      n_reads++;
      if (first_read < 0) first_read = cyc_no;
      check("read_on_empty", 32'(fifo_empty), 32'd0);
    end
    if (out_valid && out_ready) begin
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
      n_pop++;
      if (first_pop < 0) first_pop = cyc_no;
      last_pop = cyc_no;
      cnt_model++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  // Inputs change at negedge; sample 1 time unit later, then move to the next negedge.
  task automatic cyc();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || out_valid) && k < budget) begin
      cyc();
      k++;
    end
    check("drain_in_time", 32'(k < budget), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    clr_stats();

    // Reset state with a preloaded FIFO
    push_word(4'd1); push_word(4'd2); push_word(4'd3); push_word(4'd5);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;

    // Streaming four words at full rate
    clr_stats();
    repeat (8) cyc();
    check("t1_first_read", 32'(first_read), 32'd1);
    check("t1_latency", 32'(first_pop - first_read), 32'd2);
    check("t1_reads", 32'(n_reads), 32'd4);
    check("t1_pops", 32'(n_pop), 32'd4);
    check("t1_back_to_back", 32'(last_pop - first_pop), 32'd3);
    check("t1_idle_valid", 32'(out_valid), 32'd0);

    // Backpressure: only two reads while the consumer stalls
    out_ready = 1'b0;
    clr_stats();
    for (int i = 1; i <= 8; i++) push_word(4'(i));
    repeat (6) cyc();
    check("t2_reads", 32'(n_reads), 32'd2);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_head", 32'(out_data), 32'd1);
    check("t2_read_low", 32'(fifo_read), 32'd0);
    out_ready = 1'b1;
    clr_stats();
    drain(100);
    check("t2_pops", 32'(n_pop), 32'd8);
    check("t2_no_gaps", 32'(last_pop - first_pop), 32'd7);

    // Enable dropped right after a read
    enable = 1'b0;
    push_word(4'd9); push_word(4'd10); push_word(4'd11);
    clr_stats();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (6) cyc();
    check("t3_reads", 32'(n_reads), 32'd1);
    check("t3_pops", 32'(n_pop), 32'd1);
    enable = 1'b1;
    drain(50);
    check("t3_total_pops", 32'(n_pop), 32'd3);

    // Alternating out_ready
    push_word(4'd6); push_word(4'd7); push_word(4'd8);
    push_word(4'd1); push_word(4'd2); push_word(4'd3);
    clr_stats();
    for (int k = 0; k < 60 && (exp_q.size() > 0 || out_valid || k == 0); k++) begin
      out_ready = (k % 2 == 0);
      cyc();
    end
    check("t4_pops", 32'(n_pop), 32'd6);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a full buffer
    out_ready = 1'b0;
    push_word(4'd4); push_word(4'd12);
    repeat (5) cyc();
    check("t5_full_valid", 32'(out_valid), 32'd1);
    check("t5_full_head", 32'(out_data), 32'd4);
    check("t5_fifo_drained", 32'(fifo_empty), 32'd1);
    #2;
    reset = 1'b0;
    cnt_model = 0;
    exp_q.delete();
    prev_stall = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_count", 32'(word_count), 32'd0);
    check("t5_async_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    clr_stats();
    repeat (5) cyc();
    check("t5_no_reads", 32'(n_reads), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);

    // Counter wrap over five words
    for (int i = 1; i <= 5; i++) push_word(4'(i));
    clr_stats();
    drain(50);
    check("t6_pops", 32'(n_pop), 32'd5);
`ifdef FIFO_READ_CTRL_CNT_EN
    check("t6_word_count", 32'(word_count), 32'd1);
`else
    check("t6_word_count", 32'(word_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
